// File: rtl/uart_autobaud_ctrl_pkg.sv
// Shared definitions for the auto-baud calibrator: counter width, sync character,
// deviation tolerance and the calibration FSM encoding.
package uart_autobaud_ctrl_pkg;

   localparam int         CNT_W     = 19;
   localparam int         TOL_SHIFT = 3;
   localparam logic [7:0] SYNC_CHAR = 8'h55;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ARM,
      S_MEAS,
      S_CALC,
      S_STOP,
      S_LOCK,
      S_LOCKED
   } state_e;

   function automatic logic [CNT_W-1:0] abs_diff(input logic [CNT_W-1:0] a,
                                                 input logic [CNT_W-1:0] b);
      return (a >= b) ? (a - b) : (b - a);
   endfunction

endpackage

// File: rtl/uart_edge_timer.sv
// Line synchroniser, falling-edge detector and a saturating interval counter that
// restarts on every falling edge of the synchronised line.
module uart_edge_timer
   import uart_autobaud_ctrl_pkg::*;
(
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             rx_i,
   output logic             rx_o,
   output logic             fall_o,
   output logic [CNT_W-1:0] cnt_o
);

   logic [1:0]       sync_q;
   logic             prev_q;
   logic [CNT_W-1:0] cnt_q;

   assign rx_o   = sync_q[1];
   assign fall_o = prev_q & ~sync_q[1];
   assign cnt_o  = cnt_q;

   // Counter reads N exactly N clocks after the edge that restarted it.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sync_q <= 2'b11;
         prev_q <= 1'b1;
         cnt_q  <= '0;
      end else begin
         sync_q <= {sync_q[0], rx_i};
         prev_q <= sync_q[1];
         if (fall_o) begin
            cnt_q <= CNT_W'(1);
         end else if (cnt_q != '1) begin
            cnt_q <= cnt_q + CNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/uart_autobaud_ctrl.sv
// Auto-baud calibrator: measures a 0x55 sync character, drives the receiver's
// clocks-per-bit and gates its data-valid strobe until lock plus a guard time.
module uart_autobaud_ctrl
   import uart_autobaud_ctrl_pkg::*;
#(
   parameter logic [15:0] DEFAULT_CPB = 16'd87,
   parameter logic [15:0] MIN_CPB     = 16'd8,
   parameter logic [15:0] MAX_CPB     = 16'd255,
   parameter logic [15:0] IDLE_CLKS   = 16'd512,
   parameter logic [7:0]  GUARD_BITS  = 8'd12
)
(
   input  logic        i_Clock,
   input  logic        i_Reset,
   input  logic        i_Rx_Serial,
   input  logic        i_Recal,
   input  logic        i_Rx_DV,
   input  logic [7:0]  i_Rx_Byte,
   output logic [15:0] o_Clks_Per_Bit,
   output logic        o_Locked,
   output logic        o_Cal_Err,
   output logic [7:0]  o_Err_Count,
   output logic        o_Rx_DV,
   output logic [7:0]  o_Rx_Byte
);

   localparam logic [CNT_W-1:0] TIMEOUT = CNT_W'({MAX_CPB, 1'b0}) + CNT_W'(MAX_CPB >> 2);

   state_e           state_q;
   logic [15:0]      idle_q;
   logic [2:0]       edge_idx_q;
   logic [CNT_W-1:0] ref_q;
   logic [CNT_W-1:0] total_q;
   logic [15:0]      cpb_q;
   logic [23:0]      guard_q;
   logic             guard_done_q;
   logic [15:0]      clks_per_bit_q;
   logic             locked_q;
   logic             cal_err_q;
   logic [7:0]       err_count_q;

   logic             rx_s;
   logic             fall;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] dev;
   logic [CNT_W-1:0] stop_tgt;
   logic [15:0]      cpb_calc;
   logic             cal_fail;

   uart_edge_timer u_edge_timer (
      .clk_i  (i_Clock),
      .rst_i  (i_Reset),
      .rx_i   (i_Rx_Serial),
      .rx_o   (rx_s),
      .fall_o (fall),
      .cnt_o  (cnt)
   );

   assign dev      = abs_diff(cnt, ref_q);
   assign cpb_calc = 16'((total_q + CNT_W'(4)) >> 3);
   assign stop_tgt = CNT_W'(cpb_q) + CNT_W'(cpb_q >> 1);

   // First interval is the reference; later ones must stay within 1/8 of it.
   always_comb begin
      cal_fail = 1'b0;
      case (state_q)
         S_MEAS: cal_fail = (cnt > TIMEOUT) ||
                            (fall && (edge_idx_q != 3'd1) && (dev > (ref_q >> TOL_SHIFT)));
         S_CALC: cal_fail = (cpb_calc < MIN_CPB) || (cpb_calc > MAX_CPB);
         S_STOP: cal_fail = (cnt >= stop_tgt) && !rx_s;
         default: cal_fail = 1'b0;
      endcase
   end

   always_ff @(posedge i_Clock) begin
      if (i_Reset) begin
         state_q        <= S_IDLE;
         idle_q         <= '0;
         edge_idx_q     <= '0;
         ref_q          <= '0;
         total_q        <= '0;
         cpb_q          <= DEFAULT_CPB;
         guard_q        <= '0;
         guard_done_q   <= 1'b0;
         clks_per_bit_q <= DEFAULT_CPB;
         locked_q       <= 1'b0;
         cal_err_q      <= 1'b0;
         err_count_q    <= '0;
      end else begin
         cal_err_q <= 1'b0;
         if (i_Recal) begin
            locked_q     <= 1'b0;
            guard_done_q <= 1'b0;
            idle_q       <= '0;
            state_q      <= S_IDLE;
         end else if (cal_fail) begin
            cal_err_q   <= 1'b1;
            err_count_q <= (err_count_q == 8'hFF) ? err_count_q : err_count_q + 8'd1;
            idle_q      <= '0;
            state_q     <= S_IDLE;
         end else begin
            case (state_q)
               S_IDLE: begin
                  if (!rx_s) begin
                     idle_q <= '0;
                  end else if (idle_q >= IDLE_CLKS - 16'd1) begin
                     idle_q  <= '0;
                     state_q <= S_ARM;
                  end else begin
                     idle_q <= idle_q + 16'd1;
                  end
               end
               S_ARM: begin
                  if (fall) begin
                     edge_idx_q <= 3'd1;
                     total_q    <= '0;
                     state_q    <= S_MEAS;
                  end
               end
               S_MEAS: begin
                  if (fall) begin
                     if (edge_idx_q == 3'd1) begin
                        ref_q <= cnt;
                     end
                     total_q    <= total_q + cnt;
                     edge_idx_q <= edge_idx_q + 3'd1;
                     if (edge_idx_q == 3'd4) begin
                        state_q <= S_CALC;
                     end
                  end
               end
               S_CALC: begin
                  cpb_q   <= cpb_calc;
                  state_q <= S_STOP;
               end
               S_STOP: begin
                  if (cnt >= stop_tgt) begin
                     state_q <= S_LOCK;
                  end
               end
               S_LOCK: begin
                  clks_per_bit_q <= cpb_q;
                  locked_q       <= 1'b1;
                  guard_q        <= 24'(GUARD_BITS) * 24'(cpb_q);
                  guard_done_q   <= 1'b0;
                  state_q        <= S_LOCKED;
               end
               S_LOCKED: begin
                  if (guard_q != '0) begin
                     guard_q <= guard_q - 24'd1;
                  end else begin
                     guard_done_q <= 1'b1;
                  end
               end
               default: state_q <= S_IDLE;
            endcase
         end
      end
   end

   assign o_Clks_Per_Bit = clks_per_bit_q;
   assign o_Locked       = locked_q;
   assign o_Cal_Err      = cal_err_q;
   assign o_Err_Count    = err_count_q;
   assign o_Rx_DV        = i_Rx_DV & locked_q & guard_done_q;
   assign o_Rx_Byte      = i_Rx_Byte;

endmodule

// File: tb/tb_uart_autobaud_ctrl.sv
// Directed and randomized sync-character scenarios checked against a
// behavioural calibration model.
module tb_uart_autobaud_ctrl;
   import uart_autobaud_ctrl_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        rx;
   logic        recal;
   logic        dv_in;
   logic [7:0]  byte_in;
   logic [15:0] cpb_out;
   logic        locked;
   logic        cal_err;
   logic [7:0]  err_count;
   logic        dv_out;
   logic [7:0]  byte_out;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int err_pulses = 0;
   int last_err_cyc = 0;
   int lock_cyc = -1;
   logic locked_prev = 1'b0;
   int exp_err = 0;
   int exp_cpb = 87;

   always #50 clk = ~clk;

   uart_autobaud_ctrl dut (
      .i_Clock        (clk),
      .i_Reset        (rst),
      .i_Rx_Serial    (rx),
      .i_Recal        (recal),
      .i_Rx_DV        (dv_in),
      .i_Rx_Byte      (byte_in),
      .o_Clks_Per_Bit (cpb_out),
      .o_Locked       (locked),
      .o_Cal_Err      (cal_err),
      .o_Err_Count    (err_count),
      .o_Rx_DV        (dv_out),
      .o_Rx_Byte      (byte_out)
   );

   always @(posedge clk) cyc++;

   always @(negedge clk) begin
      if (cal_err === 1'b1) begin
         err_pulses++;
         last_err_cyc = cyc;
      end
      if (locked === 1'b1 && locked_prev !== 1'b1) lock_cyc = cyc;
      locked_prev = locked;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic pulse_recal();
      recal = 1'b1;
      step(1);
      recal = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] d, input int b);
      rx = 1'b0;
      step(b);
      for (int i = 0; i < 8; i++) begin
         rx = d[i];
         step(b);
      end
      rx = 1'b1;
      step(b);
   endtask

   // Falling edges E1..E5 with E(k)->E(k+1) = iv[k]; d7 low for b, then stop level for 2b.
   task automatic send_iv(input int b, input int i0, input int i1, input int i2,
                          input int i3, input bit stop_high);
      int iv[4];
      iv = '{i0, i1, i2, i3};
      for (int k = 0; k < 4; k++) begin
         rx = 1'b0;
         step(b);
         rx = 1'b1;
         step(iv[k] - b);
      end
      rx = 1'b0;
      step(b);
      rx = stop_high;
      step(2 * b);
      rx = 1'b1;
   endtask

   // Outcome of one calibration attempt computed straight from the rules.
   function automatic bit model_lock(input int b, input int i0, input int i1, input int i2,
                                     input int i3, input bit stop_high, output int cpb);
      int iv[4];
      int total;
      int tgt;
      int d;
      iv = '{i0, i1, i2, i3};
      cpb = 0;
      total = 0;
      for (int k = 0; k < 4; k++) begin
         if (iv[k] > 2 * 255 + 255 / 4) return 1'b0;
         d = (iv[k] > iv[0]) ? iv[k] - iv[0] : iv[0] - iv[k];
         if (k > 0 && d > iv[0] / 8) return 1'b0;
         total += iv[k];
      end
      cpb = (total + 4) / 8;
      if (cpb < 8 || cpb > 255) return 1'b0;
      tgt = cpb + cpb / 2;
      if (tgt < b) return 1'b0;
      if (!stop_high && tgt < 3 * b) return 1'b0;
      return 1'b1;
   endfunction

   task automatic run_case(input string tag, input int b, input int i0, input int i1,
                           input int i2, input int i3, input bit stop_high);
      int cpb;
      bit lock;
      lock = model_lock(b, i0, i1, i2, i3, stop_high, cpb);
      pulse_recal();
      rx = 1'b1;
      step(600);
      send_iv(b, i0, i1, i2, i3, stop_high);
      step(20);
      @(negedge clk);
      if (lock) exp_cpb = cpb;
      else if (exp_err < 255) exp_err++;
      $display("case %s b=%0d iv=%0d/%0d/%0d/%0d stop=%0d -> lock=%0d cpb=%0d",
               tag, b, i0, i1, i2, i3, stop_high, lock, exp_cpb);
      chk({tag, "_locked"}, 32'(locked), 32'(lock));
      chk({tag, "_cpb"}, 32'(cpb_out), 32'(exp_cpb));
      chk({tag, "_errcnt"}, 32'(err_count), 32'(exp_err));
      chk({tag, "_pulses"}, 32'(err_pulses), 32'(exp_err));
   endtask

   initial begin
      int t0;
      int lat;
      int b;
      int j;
      int iv[4];
      logic [7:0] rb;

      rst = 1'b1;
      rx = 1'b1;
      recal = 1'b0;
      dv_in = 1'b1;
      byte_in = 8'h00;
      step(5);
      @(negedge clk);
      chk("rst_cpb", 32'(cpb_out), 32'd87);
      chk("rst_locked", 32'(locked), 32'd0);
      chk("rst_calerr", 32'(cal_err), 32'd0);
      chk("rst_errcnt", 32'(err_count), 32'd0);
      chk("rst_dv_gated", 32'(dv_out), 32'd0);
      step(1);
      rst = 1'b0;
      dv_in = 1'b0;

      // Reset in the middle of a measurement: no error counted.
      step(600);
      rx = 1'b0; step(87);
      rx = 1'b1; step(87);
      rx = 1'b0; step(87);
      rst = 1'b1; rx = 1'b1;
      step(2);
      rst = 1'b0;
      step(2);
      @(negedge clk);
      $display("reset abort: errcnt=%0d pulses=%0d", err_count, err_pulses);
      chk("abort_errcnt", 32'(err_count), 32'd0);
      chk("abort_pulses", 32'(err_pulses), 32'd0);
      chk("abort_cpb", 32'(cpb_out), 32'd87);

      // Nominal 0x55 at 87 clk/bit.
      step(600);
      t0 = cyc;
      lock_cyc = -1;
      send_byte(SYNC_CHAR, 87);
      @(negedge clk);
      lat = lock_cyc - t0 - 8 * 87;
      $display("sync 87: locked=%0d cpb=%0d latency_after_E5=%0d", locked, cpb_out, lat);
      chk("t1_locked", 32'(locked), 32'd1);
      chk("t1_cpb", 32'(cpb_out), 32'd87);
      chk("t1_pulses", 32'(err_pulses), 32'd0);
      chk("t1_latency", 32'(lat >= 125 && lat <= 145), 32'd1);

      // Guard window suppresses DV, then DV passes.
      step(1);
      rb = 8'($urandom);
      dv_in = 1'b1;
      byte_in = rb;
      @(negedge clk);
      $display("dv in guard: dv_out=%0d byte=%0h", dv_out, byte_out);
      chk("t2_guard_dv", 32'(dv_out), 32'd0);
      chk("t2_byte_pass", 32'(byte_out), 32'(rb));
      step(lock_cyc + 1030 - cyc);
      @(negedge clk);
      chk("t2_guard_late_dv", 32'(dv_out), 32'd0);
      step(lock_cyc + 1060 - cyc);
      dv_in = 1'b0;
      @(negedge clk);
      chk("t2_dv_idle", 32'(dv_out), 32'd0);
      step(1);
      dv_in = 1'b1;
      byte_in = 8'hA3;
      @(negedge clk);
      $display("dv after guard: dv_out=%0d byte=%0h", dv_out, byte_out);
      chk("t2_dv_pass", 32'(dv_out), 32'd1);
      chk("t2_byte_a3", 32'(byte_out), 32'hA3);
      step(1);
      dv_in = 1'b0;

      // Recalibrate request while locked.
      pulse_recal();
      dv_in = 1'b1;
      @(negedge clk);
      $display("recal locked: locked=%0d cpb=%0d", locked, cpb_out);
      chk("t6_recal_locked", 32'(locked), 32'd0);
      chk("t6_recal_cpb", 32'(cpb_out), 32'd87);
      chk("t6_recal_pulses", 32'(err_pulses), 32'd0);
      chk("t6_recal_dv", 32'(dv_out), 32'd0);
      step(1);
      dv_in = 1'b0;

      // 0x00: only E1, measurement times out.
      step(600);
      t0 = cyc;
      send_byte(8'h00, 87);
      step(5);
      @(negedge clk);
      exp_err = 1;
      lat = last_err_cyc - t0;
      $display("sync 0x00: errcnt=%0d pulses=%0d err_at=%0d", err_count, err_pulses, lat);
      chk("t3_errcnt", 32'(err_count), 32'd1);
      chk("t3_pulses", 32'(err_pulses), 32'd1);
      chk("t3_cpb", 32'(cpb_out), 32'd87);
      chk("t3_locked", 32'(locked), 32'd0);
      chk("t3_timeout_at", 32'(lat >= 570 && lat <= 584), 32'd1);

      run_case("t4_jitter_ok", 87, 174, 174, 190, 174, 1'b1);
      chk("t4_cpb89", 32'(cpb_out), 32'd89);
      run_case("t4_jitter_bad", 87, 174, 174, 200, 174, 1'b1);
      run_case("t5_stop_low", 87, 174, 174, 174, 174, 1'b0);
      run_case("t5_min_cpb", 6, 12, 12, 12, 12, 1'b1);

      // Recalibrate request in the middle of a measurement.
      pulse_recal();
      step(600);
      rx = 1'b0; step(87);
      rx = 1'b1; step(87);
      rx = 1'b0; step(87);
      pulse_recal();
      rx = 1'b1; step(86);
      rx = 1'b0; step(87);
      rx = 1'b1; step(700);
      @(negedge clk);
      $display("recal meas: locked=%0d cpb=%0d pulses=%0d", locked, cpb_out, err_pulses);
      chk("t6_meas_locked", 32'(locked), 32'd0);
      chk("t6_meas_pulses", 32'(err_pulses), 32'(exp_err));
      chk("t6_meas_cpb", 32'(cpb_out), 32'(exp_cpb));
      send_byte(SYNC_CHAR, 174);
      step(5);
      @(negedge clk);
      exp_cpb = 174;
      $display("sync 174: locked=%0d cpb=%0d", locked, cpb_out);
      chk("t6_174_locked", 32'(locked), 32'd1);
      chk("t6_174_cpb", 32'(cpb_out), 32'd174);
      chk("t6_174_pulses", 32'(err_pulses), 32'(exp_err));

      // Randomized bit times, jitter and stop-bit level.
      for (int n = 0; n < 8; n++) begin
         b = int'($urandom_range(12, 280));
         j = (2 * b) / 6;
         for (int k = 0; k < 4; k++) iv[k] = 2 * b + int'($urandom_range(0, 2 * j)) - j;
         run_case($sformatf("rnd%0d", n), b, iv[0], iv[1], iv[2], iv[3],
                  $urandom_range(0, 3) != 0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
